// File: rtl/lfsr_pkg.sv
// Shared constants and state type for the 18-bit Fibonacci PRBS generator/checker pair.
package lfsr_pkg;

  localparam int unsigned LFSR_LEN   = 18;
  localparam int unsigned LFSR_TAP_A = 18;
  localparam int unsigned LFSR_TAP_B = 11;
  localparam logic [LFSR_LEN-1:0] LFSR_SEED = 18'd1;

  typedef enum logic {
    LOAD   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc, clear_n wins over both.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the 18-bit (taps 18,11) generator: loads 18 bits,
// then flywheels a local predictor, counts mismatches and drops lock on error bursts.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned ERR_CNT_W   = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_count,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           lock_count
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned ERRS_W = $clog2(LOSS_THRESH + 1);
  localparam int unsigned FILL_W = $clog2(LFSR_LEN + 1);

  state_t              state;
  logic [LFSR_LEN:1]   h;
  logic [FILL_W-1:0]   fill;
  logic [WIN_W-1:0]    win_bits;
  logic [ERRS_W-1:0]   win_errs;

  logic                predict;
  logic                mismatch;
  logic                fill_full;
  logic                lock_now;
  logic                lose;
  logic [LFSR_LEN:1]   load_h;
  logic [ERRS_W-1:0]   win_errs_n;

  always_comb begin
    predict    = h[LFSR_TAP_A] ^ h[LFSR_TAP_B];
    mismatch   = in_valid && (state == LOCKED) && (in_bit != predict);
    load_h     = {h[LFSR_LEN-1:1], in_bit};
    fill_full  = (fill >= FILL_W'(LFSR_LEN - 1));
    lock_now   = in_valid && (state == LOAD) && fill_full && (load_h != '0);
    win_errs_n = win_errs + ERRS_W'(mismatch);
    lose       = mismatch && (win_errs_n == ERRS_W'(LOSS_THRESH));
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= LOAD;
      h        <= '0;
      fill     <= '0;
      win_bits <= '0;
      win_errs <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= mismatch;
      if (in_valid) begin
        case (state)
          LOAD: begin
            h    <= load_h;
            // Fill saturates at 18 so an all-zero history retries on every new bit.
            fill <= fill_full ? FILL_W'(LFSR_LEN) : fill + 1'b1;
            if (lock_now) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              win_bits <= '0;
              win_errs <= '0;
            end
          end
          LOCKED: begin
            if (lose) begin
              state    <= LOAD;
              locked   <= 1'b0;
              h        <= '0;
              fill     <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              h <= {h[LFSR_LEN-1:1], predict};
              // Threshold is tested before the wrap, so a last-bit error still counts.
              if (win_bits == WIN_W'(WINDOW - 1)) begin
                win_bits <= '0;
                win_errs <= '0;
              end else begin
                win_bits <= win_bits + 1'b1;
                win_errs <= win_errs_n;
              end
            end
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_count (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (clear_count),
    .inc     (mismatch),
    .count   (err_count)
  );

  sat_counter #(.WIDTH(8)) u_lock_count (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (1'b0),
    .inc     (lock_now),
    .count   (lock_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: table of stream scenarios plus hand-written corner sequences.
module tb_lfsr_checker;

  logic        clock;
  logic        clear_n;
  logic        in_valid;
  logic        in_bit;
  logic        clear_count;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [7:0]  lock_count;

  lfsr_checker #(.ERR_CNT_W(16), .WINDOW(64), .LOSS_THRESH(8)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked),
    .err         (err),
    .err_count   (err_count),
    .lock_count  (lock_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [18:1] g;
  int unsigned pulses;

  typedef struct {
    string       name;
    int unsigned duty;
    int unsigned nbits;
    int unsigned flip_at;
    int unsigned flip_len;
    int unsigned exp_errs;
    int unsigned exp_locks;
    int unsigned exp_locked;
    int unsigned exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference generator: seed 1, output stage 18, feedback stage18 ^ stage11 into stage 1.
  task automatic gen_reset();
    g = 18'd1;
  endtask

  task automatic gen_bit(output logic b);
    b = g[18];
    g = {g[17:1], g[18] ^ g[11]};
  endtask

  task automatic send(input logic v, input logic b, input logic cc);
    in_valid    = v;
    in_bit      = b;
    clear_count = cc;
    @(posedge clock);
    #1;
    if (err) pulses++;
    in_valid    = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    clear_n = 1'b1;
    pulses  = 0;
  endtask

  task automatic send_gen(input int unsigned n, input logic flip);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      gen_bit(b);
      send(1'b1, b ^ flip, 1'b0);
    end
  endtask

  task automatic run_row(input vec_t v);
    int unsigned sent;
    int unsigned first;
    int unsigned cycles;
    logic        valid;
    logic        b;
    do_reset();
    gen_reset();
    sent   = 0;
    first  = 0;
    cycles = 0;
    while ((sent < v.nbits) && (cycles < 20000)) begin
      cycles++;
      valid = (v.duty >= 100) || ($urandom_range(0, 99) < v.duty);
      if (valid) begin
        sent++;
        gen_bit(b);
        if ((sent >= v.flip_at) && (sent < v.flip_at + v.flip_len)) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      send(valid, b, 1'b0);
      if (err && (first == 0)) first = sent;
    end
    check({v.name, "_bits_sent"}, sent, v.nbits);
    check({v.name, "_err_count"}, err_count, v.exp_errs);
    check({v.name, "_lock_count"}, lock_count, v.exp_locks);
    check({v.name, "_locked"}, locked, v.exp_locked);
    check({v.name, "_err_pulses"}, pulses, v.exp_errs);
    check({v.name, "_first_err_bit"}, first, v.exp_first);
  endtask

  initial begin
    clear_n     = 1'b1;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    clear_count = 1'b0;
    pulses      = 0;
    gen_reset();

    //                name          duty nbits flip len errs locks lckd first
    vecs[0] = '{"clean",          100, 2018,   0,  0,   0,   1,   1,    0};
    vecs[1] = '{"gapped",          30, 2018,   0,  0,   0,   1,   1,    0};
    vecs[2] = '{"single_flip",    100,  600, 500,  1,   1,   1,   1,  500};
    vecs[3] = '{"burst8_loss",    100,  700, 500,  8,   8,   2,   1,  500};
    vecs[4] = '{"burst7_hold",    100,  700, 500,  7,   7,   1,   1,  500};
    vecs[5] = '{"burst8_split",   100,  700, 527,  8,   8,   1,   1,  527};
    vecs[6] = '{"burst8_lastbit", 100,  700, 523,  8,   8,   2,   1,  523};

    do_reset();
    check("reset_locked", locked, 0);
    check("reset_err", err, 0);
    check("reset_err_count", err_count, 0);
    check("reset_lock_count", lock_count, 0);

    foreach (vecs[i]) run_row(vecs[i]);

    // Lock-point timing and burst relock latency.
    do_reset();
    gen_reset();
    send_gen(17, 1'b0);
    check("lock_after_17", locked, 0);
    send_gen(1, 1'b0);
    check("lock_after_18", locked, 1);
    send_gen(500, 1'b0);
    send_gen(7, 1'b1);
    check("burst_7th_locked", locked, 1);
    send_gen(1, 1'b1);
    check("burst_8th_unlocked", locked, 0);
    check("burst_8th_err", err, 1);
    send_gen(17, 1'b0);
    check("relock_17", locked, 0);
    send_gen(1, 1'b0);
    check("relock_18", locked, 1);
    check("relock_lock_count", lock_count, 2);

    // All-zero input never locks; the generator's first 1 then completes a legal history.
    do_reset();
    for (int unsigned i = 0; i < 100; i++) send(1'b1, 1'b0, 1'b0);
    check("zeros_locked", locked, 0);
    check("zeros_err_pulses", pulses, 0);
    gen_reset();
    send_gen(17, 1'b0);
    check("zeros_then_17_locked", locked, 0);
    send_gen(1, 1'b0);
    check("zeros_then_one_locked", locked, 1);
    check("zeros_lock_count", lock_count, 1);
    send_gen(300, 1'b0);
    check("zeros_err_count", err_count, 0);
    check("zeros_err_pulses_after", pulses, 0);

    // Gaps hold state; err pulse is a single cycle.
    send_gen(1, 1'b1);
    check("flip_err", err, 1);
    check("flip_err_count", err_count, 1);
    pulses = 0;
    for (int unsigned i = 0; i < 6; i++) send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check("gap_err_pulses", pulses, 0);
    check("gap_err_count", err_count, 1);
    check("gap_locked", locked, 1);
    send_gen(1, 1'b0);
    check("clean_after_gap_err", err, 0);

    // clear_count coinciding with a mismatch leaves zero.
    begin
      logic b;
      gen_bit(b);
      send(1'b1, ~b, 1'b1);
    end
    check("clear_mismatch_err", err, 1);
    check("clear_mismatch_count", err_count, 0);
    send_gen(1, 1'b1);
    check("count_after_clear", err_count, 1);

    // Reset mid-lock wins over valid data.
    clear_n = 1'b0;
    send_gen(1, 1'b1);
    clear_n = 1'b1;
    check("midlock_reset_locked", locked, 0);
    check("midlock_reset_err", err, 0);
    check("midlock_reset_err_count", err_count, 0);
    check("midlock_reset_lock_count", lock_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's 18-bit Fibonacci LFSR pattern generator (taps 18 and 11, seed 1, serial output taken from stage 18).
- Consumes the serial PRBS stream one bit per in_valid cycle and self-synchronises by loading 18 received bits.
- Then free-runs a local predictor, flags every mismatching bit and counts errors.
- Declares loss of lock on an error burst and re-acquires automatically. Used on link/loopback tests of the generator.

Parameters:
ERR_CNT_W, 16, width of the saturating error counter
WINDOW, 64, number of checked bits per loss-of-lock observation window (>= 2)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WINDOW)

Ports:
clock  input  1  sole clock; all state updates on posedge
clear_n  input  1  synchronous active-low reset
in_valid  input  1  in_bit is sampled on this posedge
in_bit  input  1  received serial PRBS bit
clear_count  input  1  synchronous zeroing of err_count (no effect on lock state)
locked  output  1  high while the predictor is synchronised
err  output  1  one-cycle pulse: last checked bit mismatched
err_count  output  ERR_CNT_W  total mismatches since reset/clear_count, saturating
lock_count  output  8  number of LOAD->LOCKED transitions, saturating at 255

Behaviour:
- Sequence law: the generator stream obeys b[j] = b[j-11] ^ b[j-18]. History register h[18:1]: h[1] = newest bit, h[k] = bit received k valid-bits ago. Prediction p = h[11] ^ h[18].
- Reset (clear_n=0 at posedge):
  - state=LOAD, h=0, fill counter=0, window counters=0.
  - locked=0, err=0, err_count=0, lock_count=0.
  - clear_n overrides all other inputs.
- State LOAD, per valid bit:
  - Shift in_bit into h; fill++.
  - On the 18th bit, go to LOCKED only if the resulting h != 0.
  - If h == 0 (an all-zero history is illegal and would lock onto a dead stream), keep fill at 18 and stay in LOAD, retrying on every subsequent bit.
  - No comparisons are made in LOAD; err stays 0.
- Entering LOCKED: lock_count++ (saturating); window bit and error counters cleared; locked visible from the cycle after that edge.
- State LOCKED, per valid bit:
  - Compare in_bit with p.
  - Shift p, not in_bit, into h (flywheel), so one flipped bit yields exactly one error.
  - On mismatch: err=1 next cycle, err_count++ (saturating at all-ones), window_errs++.
- Window rules:
  - Window bit counter wraps after WINDOW checked bits, clearing window_errs.
  - An error on the last bit of a window counts toward that window before the clear.
- Loss of lock:
  - When window_errs reaches LOSS_THRESH, go to LOAD on that same edge: fill=0, h=0, locked=0 next cycle.
  - The offending error is still pulsed and counted.
- in_valid=0: no shift, no compare, err=0; all counters hold.
- err is 0 on every cycle not immediately following a checked mismatch.
- clear_count=1 zeroes err_count. If it coincides with a mismatch, the result is 0, not 1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package lfsr_pkg holds shared constants: LFSR_LEN=18, LFSR_TAP_A=18, LFSR_TAP_B=11, LFSR_SEED=18'd1. The generator is to be migrated to the same package.
- Package also holds the state enum {LOAD, LOCKED}.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturating). It is instantiated for err_count and lock_count.

Test Plan:
- Clean stream: drive the generator (seed 1, first 17 bits 0, 18th bit 1) into the checker with in_valid=1 continuously -> locked rises after bit 18; lock_count=1; 2000 further bits give err_count=0 and err never high.
- Single flip: invert bit 500 of a locked stream -> exactly one err pulse, on the cycle after bit 500; err_count=1; locked stays 1; no errors at bits 511 or 518.
- Burst loss: with WINDOW=64 and LOSS_THRESH=8, invert 8 consecutive bits -> err_count=8; locked drops after the 8th error; relock 18 valid bits later; lock_count=2.
- All-zero input: 100 zero bits after reset -> locked stays 0, err never pulses; a subsequent 1 followed by a valid generator sequence locks.
- Gapped valid: random in_valid duty of 30% on a clean stream -> same results as the clean-stream case; counters hold during gaps.
- Reset and clear: assert clear_n=0 mid-lock -> next cycle locked=0, err_count=0, lock_count=0. Pulse clear_count together with a mismatch -> err_count=0.
